// File: rtl/div_pipe_sat.sv
// div_pipe_sat: fully pipelined signed fixed-point divider, o = a / b.
// The quotient is truncated toward zero and clamped to [SAT_LO, SAT_HI].
// Divide by zero is flagged on o_dz and returns a signed clamp value.
// Structure: an input register (stage 0), NSTG restoring-division stages
// resolving R quotient bits each, and a registered sign/clamp stage.
// Latency is NSTG + 2 enabled cycles. i_en = 0 freezes every register.
module div_pipe_sat #(
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int O_I_W = 4,
    parameter int O_F_W = 16,
    parameter int O_W = O_I_W + O_F_W,
    parameter int R = 2,
    parameter logic [O_W-1:0] SAT_HI = 20'h5ABD9,
    parameter logic [O_W-1:0] SAT_LO = 20'hA5426
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_valid,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           o_valid,
    output logic [O_W-1:0] o,
    output logic           o_sat,
    output logic           o_dz
);

    // Quotient magnitude width and the number of division stages.
    localparam int Q_W  = A_W + O_F_W;
    localparam int NSTG = (Q_W + R - 1) / R;
    // Comparison width: wide enough for the signed quotient and the clamps.
    localparam int CW   = (Q_W + 1 > O_W) ? Q_W + 1 : O_W;

    // Magnitudes of the operands. Unsigned widths keep -2^(W-1) representable.
    logic [A_W-1:0] abs_a;
    logic [B_W-1:0] abs_b;

    // Per-stage pipeline registers. Index 0 is the input register; index k
    // holds the result of division stage k. The remainder and divisor are not
    // needed after the last division stage, so those arrays stop at NSTG-1.
    // nq_r carries {unconsumed dividend bits, quotient bits so far}: each bit
    // step shifts one dividend bit out of the top and one quotient bit in.
    logic [B_W:0]   rem_r  [0:NSTG-1];
    logic [B_W-1:0] d_r    [0:NSTG-1];
    logic [Q_W-1:0] nq_r   [0:NSTG];
    logic           sign_r [0:NSTG];
    logic           sa_r   [0:NSTG];
    logic           dz_r   [0:NSTG];
    logic           az_r   [0:NSTG];
    logic           v_r    [0:NSTG];

    // Next-state values for the pipeline registers.
    logic [B_W:0]   rem_n  [0:NSTG-1];
    logic [B_W-1:0] d_n    [0:NSTG-1];
    logic [Q_W-1:0] nq_n   [0:NSTG];
    logic           sign_n [0:NSTG];
    logic           sa_n   [0:NSTG];
    logic           dz_n   [0:NSTG];
    logic           az_n   [0:NSTG];
    logic           v_n    [0:NSTG];

    // Working values of the bit-step chain inside one stage.
    logic [B_W:0]   rem_t;
    logic [B_W:0]   rem_sh;
    logic [Q_W-1:0] nq_t;

    // Final-stage signals.
    logic [CW-1:0]        q_mag;
    logic signed [CW-1:0] q_ext;
    logic signed [CW-1:0] hi_ext;
    logic signed [CW-1:0] lo_ext;
    logic [O_W-1:0]       o_n;
    logic                 sat_n;
    logic                 dz_out_n;

    assign abs_a = a[A_W-1] ? (~a + 1'b1) : a;
    assign abs_b = b[B_W-1] ? (~b + 1'b1) : b;

    // Stage 0 capture plus the R-bit restoring division steps of every stage.
    always_comb begin
        rem_n  = '{default: '0};
        d_n    = '{default: '0};
        nq_n   = '{default: '0};
        sign_n = '{default: 1'b0};
        sa_n   = '{default: 1'b0};
        dz_n   = '{default: 1'b0};
        az_n   = '{default: 1'b0};
        v_n    = '{default: 1'b0};
        rem_t  = '0;
        rem_sh = '0;
        nq_t   = '0;

        rem_n[0]  = '0;
        d_n[0]    = abs_b;
        nq_n[0]   = {abs_a, {O_F_W{1'b0}}};
        sign_n[0] = a[A_W-1] ^ b[B_W-1];
        sa_n[0]   = a[A_W-1];
        dz_n[0]   = (b == '0);
        az_n[0]   = (a == '0);
        v_n[0]    = i_valid;

        for (int k = 1; k <= NSTG; k++) begin
            rem_t = rem_r[k-1];
            nq_t  = nq_r[k-1];
            for (int j = 0; j < R; j++) begin
                // Bit positions past Q_W (partial last stage) are skipped.
                if ((k - 1) * R + j < Q_W) begin
                    rem_sh = {rem_t[B_W-1:0], nq_t[Q_W-1]};
                    nq_t   = {nq_t[Q_W-2:0], 1'b0};
                    if (rem_sh >= {1'b0, d_r[k-1]}) begin
                        rem_t   = rem_sh - {1'b0, d_r[k-1]};
                        nq_t[0] = 1'b1;
                    end else begin
                        rem_t = rem_sh;
                    end
                end
            end
            if (k < NSTG) begin
                rem_n[k] = rem_t;
                d_n[k]   = d_r[k-1];
            end
            nq_n[k]   = nq_t;
            sign_n[k] = sign_r[k-1];
            sa_n[k]   = sa_r[k-1];
            dz_n[k]   = dz_r[k-1];
            az_n[k]   = az_r[k-1];
            v_n[k]    = v_r[k-1];
        end
    end

    // Data registers: no reset needed, they are qualified by the valid chain.
    always_ff @(posedge clk) begin
        if (i_en) begin
            rem_r  <= rem_n;
            d_r    <= d_n;
            nq_r   <= nq_n;
            sign_r <= sign_n;
            sa_r   <= sa_n;
            dz_r   <= dz_n;
            az_r   <= az_n;
        end
    end

    // Valid chain: reset flushes in-flight operations, and wins over a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '{default: 1'b0};
        end else if (i_en) begin
            v_r <= v_n;
        end
    end

    // Sign application, divide-by-zero handling and clamping of the quotient.
    always_comb begin
        q_mag    = CW'({1'b0, nq_r[NSTG]});
        q_ext    = sign_r[NSTG] ? -$signed(q_mag) : $signed(q_mag);
        hi_ext   = CW'($signed(SAT_HI));
        lo_ext   = CW'($signed(SAT_LO));
        o_n      = q_ext[O_W-1:0];
        sat_n    = 1'b0;
        dz_out_n = 1'b0;

        if (dz_r[NSTG]) begin
            dz_out_n = 1'b1;
            if (az_r[NSTG]) begin
                o_n = '0;
            end else begin
                // Only the dividend's sign picks the direction: b = 0 has none.
                o_n = sa_r[NSTG] ? SAT_LO : SAT_HI;
            end
        end else if (q_ext > hi_ext) begin
            o_n   = SAT_HI;
            sat_n = 1'b1;
        end else if (q_ext < lo_ext) begin
            o_n   = SAT_LO;
            sat_n = 1'b1;
        end
    end

    // Output register: holds through stalls, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o       <= '0;
            o_sat   <= 1'b0;
            o_dz    <= 1'b0;
        end else if (i_en) begin
            o_valid <= v_r[NSTG];
            o       <= o_n;
            o_sat   <= sat_n;
            o_dz    <= dz_out_n;
        end
    end

endmodule

// File: tb/tb_div_pipe_sat.sv
// Testbench for div_pipe_sat: directed quotients, saturation, divide by zero,
// a wider R=4 instance with a partial last stage, random streaming with
// bubbles and stalls against an integer reference, and reset flushing.
module tb_div_pipe_sat;

    localparam int LAT  = 14;
    localparam int LAT4 = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vin;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ov;
    logic [19:0] o;
    logic        osat;
    logic        odz;

    logic        en4;
    logic        v4;
    logic [9:0]  a4;
    logic [9:0]  b4;
    logic        ov4;
    logic [19:0] o4;
    logic        osat4;
    logic        odz4;

    int tests = 0;
    int fails = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    div_pipe_sat dut (
        .clk(clk), .rst(rst), .i_en(en), .i_valid(vin), .a(a), .b(b),
        .o_valid(ov), .o(o), .o_sat(osat), .o_dz(odz)
    );

    div_pipe_sat #(.A_W(10), .B_W(10), .R(4)) dut4 (
        .clk(clk), .rst(rst), .i_en(en4), .i_valid(v4), .a(a4), .b(b4),
        .o_valid(ov4), .o(o4), .o_sat(osat4), .o_dz(odz4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integer reference: a * 2^16 / b truncated toward zero, then clamped.
    function automatic void model(input int av, input int bv,
                                  output logic [19:0] eo, output logic es, output logic ed);
        longint q;
        longint hi = 371673;
        longint lo = -371674;
        es = 1'b0;
        ed = 1'b0;
        eo = '0;
        if (bv == 0) begin
            ed = 1'b1;
            if (av == 0)     eo = 20'h00000;
            else if (av < 0) eo = 20'hA5426;
            else             eo = 20'h5ABD9;
        end else begin
            q = (longint'(av) * 64'sd65536) / longint'(bv);
            if (q > hi) begin
                eo = 20'h5ABD9;
                es = 1'b1;
            end else if (q < lo) begin
                eo = 20'hA5426;
                es = 1'b1;
            end else begin
                eo = q[19:0];
            end
        end
    endfunction

    // Issue one pair on the default instance and count cycles to o_valid.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, output int lat);
        en  = 1'b1;
        vin = 1'b1;
        a   = av;
        b   = bv;
        tick();
        vin = 1'b0;
        lat = 1;
        while (ov !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic issue4(input logic [9:0] av, input logic [9:0] bv, output int lat);
        en4 = 1'b1;
        v4  = 1'b1;
        a4  = av;
        b4  = bv;
        tick();
        v4  = 1'b0;
        lat = 1;
        while (ov4 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        vin = 1'b0;
        repeat (3) tick();
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ov); end
        tests++; if (o !== 20'h0) begin fails++; $display("FAIL reset_o: got %h want 00000", o); end
        tests++; if (osat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", osat); end
        tests++; if (odz !== 1'b0) begin fails++; $display("FAIL reset_dz: got %b want 0", odz); end
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_valid4: got %b want 0", ov4); end
        rst = 1'b0;
        en  = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0]  va [6];
        logic [7:0]  vb [6];
        logic [19:0] ve [6];
        int lat;
        va = '{8'd3, 8'd1, 8'hFF, 8'h80, 8'd0, 8'd7};
        vb = '{8'd1, 8'd3, 8'd3,  8'h80, 8'd5, 8'hFE};
        ve = '{20'h30000, 20'h05555, 20'hFAAAB, 20'h10000, 20'h00000, 20'hC8000};
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], lat);
            tests++; if (lat != LAT) begin fails++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, LAT); end
            tests++; if (o !== ve[i]) begin fails++; $display("FAIL basic_o[%0d]: got %h want %h", i, o, ve[i]); end
            tests++; if (osat !== 1'b0) begin fails++; $display("FAIL basic_sat[%0d]: got %b want 0", i, osat); end
            tests++; if (odz !== 1'b0) begin fails++; $display("FAIL basic_dz[%0d]: got %b want 0", i, odz); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [19:0] ve [4];
        int lat;
        va = '{8'd10, 8'hF6, 8'd127, 8'h80};
        vb = '{8'd1,  8'd1,  8'hFF,  8'd1};
        ve = '{20'h5ABD9, 20'hA5426, 20'hA5426, 20'hA5426};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], lat);
            tests++; if (lat != LAT) begin fails++; $display("FAIL sat_lat[%0d]: got %0d want %0d", i, lat, LAT); end
            tests++; if (o !== ve[i]) begin fails++; $display("FAIL sat_o[%0d]: got %h want %h", i, o, ve[i]); end
            tests++; if (osat !== 1'b1) begin fails++; $display("FAIL sat_flag[%0d]: got %b want 1", i, osat); end
            tests++; if (odz !== 1'b0) begin fails++; $display("FAIL sat_dz[%0d]: got %b want 0", i, odz); end
        end
    endtask

    task automatic test_divzero();
        logic [7:0]  va [3];
        logic [19:0] ve [3];
        int lat;
        va = '{8'd5, 8'hFB, 8'd0};
        ve = '{20'h5ABD9, 20'hA5426, 20'h00000};
        for (int i = 0; i < 3; i++) begin
            issue(va[i], 8'd0, lat);
            tests++; if (lat != LAT) begin fails++; $display("FAIL dz_lat[%0d]: got %0d want %0d", i, lat, LAT); end
            tests++; if (o !== ve[i]) begin fails++; $display("FAIL dz_o[%0d]: got %h want %h", i, o, ve[i]); end
            tests++; if (osat !== 1'b0) begin fails++; $display("FAIL dz_sat[%0d]: got %b want 0", i, osat); end
            tests++; if (odz !== 1'b1) begin fails++; $display("FAIL dz_flag[%0d]: got %b want 1", i, odz); end
        end
    endtask

    // R=4, 10-bit operands: Q_W=26 leaves a 2-bit last stage.
    task automatic test_r4_corners();
        logic [9:0]  va [8];
        logic [9:0]  vb [8];
        logic [19:0] ve [8];
        logic        vs [8];
        logic        vd [8];
        int lat;
        va = '{10'h200, 10'd1, 10'h3FF, 10'h1FF, 10'h200, 10'd5, 10'd0, 10'd1};
        vb = '{10'h200, 10'd3, 10'd3,   10'h200, 10'd1,   10'd0, 10'd0, 10'h200};
        ve = '{20'h10000, 20'h05555, 20'hFAAAB, 20'hF0080, 20'hA5426, 20'h5ABD9, 20'h00000, 20'hFFF80};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue4(va[i], vb[i], lat);
            tests++; if (lat != LAT4) begin fails++; $display("FAIL r4_lat[%0d]: got %0d want %0d", i, lat, LAT4); end
            tests++; if (o4 !== ve[i]) begin fails++; $display("FAIL r4_o[%0d]: got %h want %h", i, o4, ve[i]); end
            tests++; if (osat4 !== vs[i]) begin fails++; $display("FAIL r4_sat[%0d]: got %b want %b", i, osat4, vs[i]); end
            tests++; if (odz4 !== vd[i]) begin fails++; $display("FAIL r4_dz[%0d]: got %b want %b", i, odz4, vd[i]); end
        end
    endtask

    // Random stream with bubbles and optional stalls. One queue entry per
    // enabled edge; the entry LAT enabled edges old must be at the output.
    task automatic test_stream(input string name, input int n, input int stall_pct, input int bubble_pct);
        logic        q_v [$];
        logic [19:0] q_o [$];
        logic        q_s [$];
        logic        q_d [$];
        logic        ev, es, ed, last_en, p_v, p_s, p_d;
        logic [19:0] eo, p_o;
        int issued = 0;
        int pending = 0;
        int cyc = 0;
        while ((issued < n || pending > 0) && cyc < 20000) begin
            en  = ($urandom_range(0, 99) >= stall_pct);
            vin = (issued < n) && ($urandom_range(0, 99) >= bubble_pct);
            a   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b   = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (en) begin
                model(int'($signed(a)), int'($signed(b)), eo, es, ed);
                q_v.push_back(vin);
                q_o.push_back(eo);
                q_s.push_back(es);
                q_d.push_back(ed);
                if (vin) begin
                    issued++;
                    pending++;
                end
            end
            last_en = en;
            p_v = ov; p_o = o; p_s = osat; p_d = odz;
            tick();
            cyc++;
            if (last_en) begin
                if (q_v.size() == LAT) begin
                    ev = q_v.pop_front();
                    eo = q_o.pop_front();
                    es = q_s.pop_front();
                    ed = q_d.pop_front();
                    tests++; if (ov !== ev) begin fails++; $display("FAIL %s_valid cyc %0d: got %b want %b", name, cyc, ov, ev); end
                    if (ev) begin
                        pending--;
                        tests++; if (o !== eo) begin fails++; $display("FAIL %s_o cyc %0d: got %h want %h", name, cyc, o, eo); end
                        tests++; if (osat !== es) begin fails++; $display("FAIL %s_sat cyc %0d: got %b want %b", name, cyc, osat, es); end
                        tests++; if (odz !== ed) begin fails++; $display("FAIL %s_dz cyc %0d: got %b want %b", name, cyc, odz, ed); end
                    end
                end else begin
                    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL %s_fill cyc %0d: got %b want 0", name, cyc, ov); end
                end
            end else begin
                tests++; if (ov !== p_v) begin fails++; $display("FAIL %s_hold_valid cyc %0d: got %b want %b", name, cyc, ov, p_v); end
                tests++; if (o !== p_o) begin fails++; $display("FAIL %s_hold_o cyc %0d: got %h want %h", name, cyc, o, p_o); end
                tests++; if (osat !== p_s) begin fails++; $display("FAIL %s_hold_sat cyc %0d: got %b want %b", name, cyc, osat, p_s); end
                tests++; if (odz !== p_d) begin fails++; $display("FAIL %s_hold_dz cyc %0d: got %b want %b", name, cyc, odz, p_d); end
            end
        end
        tests++; if (pending != 0) begin fails++; $display("FAIL %s_timeout: got %0d results outstanding want 0", name, pending); end
        en  = 1'b1;
        vin = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_back_to_back();
        test_stream("stream", 1000, 0, 20);
    endtask

    task automatic test_stall();
        test_stream("stall", 400, 30, 15);
    endtask

    task automatic test_mid_reset();
        int lat;
        int stale;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vin = 1'b1;
            a   = 8'(i + 1);
            b   = 8'd3;
            tick();
        end
        vin = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", ov); end
        tests++; if (o !== 20'h0) begin fails++; $display("FAIL midrst_o: got %h want 00000", o); end
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov !== 1'b0) stale++;
        end
        tests++; if (stale != 0) begin fails++; $display("FAIL midrst_stale: got %0d valid beats want 0", stale); end
        issue(8'd7, 8'd2, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL midrst_lat: got %0d want %0d", lat, LAT); end
        tests++; if (o !== 20'h38000) begin fails++; $display("FAIL midrst_o_new: got %h want 38000", o); end

        // Reset while stalled with a valid result on the output.
        issue(8'd3, 8'd1, lat);
        tests++; if (ov !== 1'b1) begin fails++; $display("FAIL stallrst_pre: got %b want 1", ov); end
        en  = 1'b0;
        rst = 1'b1;
        tick();
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL stallrst_valid: got %b want 0", ov); end
        tests++; if (o !== 20'h0) begin fails++; $display("FAIL stallrst_o: got %h want 00000", o); end
        rst = 1'b0;
        en  = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov !== 1'b0) stale++;
        end
        tests++; if (stale != 0) begin fails++; $display("FAIL stallrst_stale: got %0d valid beats want 0", stale); end
    endtask

    // Upper bound on run time in case a wait escapes its cycle budget.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        vin = 1'b0;
        a   = '0;
        b   = '0;
        en4 = 1'b1;
        v4  = 1'b0;
        a4  = '0;
        b4  = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_divzero();
        test_r4_corners();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_pipe_sat.md
# div_pipe_sat

Parametrised, fully pipelined signed fixed-point divider with valid tracking, a global stall, and configurable saturation. It replaces the fixed 8-bit, externally-signed gradient-ratio divider in the HOG orientation path. It computes o = a / b for two's-complement a and b, truncated toward zero. The result is clamped to a programmable window (default tan80/tan100 in Q4.16) and divide-by-zero is flagged. One result is accepted per enabled cycle.

## Interface
- A_W, 8: dividend width, signed.
- B_W, 8: divisor width, signed.
- O_I_W, 4: output integer bits, including sign.
- O_F_W, 16: output fraction bits.
- O_W, O_I_W+O_F_W: output width (derived; do not override).
- R, 2: quotient bits resolved per pipeline stage (1, 2 or 4).
- SAT_HI, 20'h5ABD9: upper clamp, signed O_W.
- SAT_LO, 20'hA5426: lower clamp, signed O_W. Constraint: SAT_LO <= SAT_HI as signed values.
- Derived values:
  - Q_W = A_W + O_F_W: unsigned quotient magnitude bits.
  - NSTG = ceil(Q_W/R): default 12.
  - LAT = NSTG + 2: default 14.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_en, input, 1: pipeline advance. When 0, every register in the block holds.
- i_valid, input, 1: a and b carry an operand pair.
- a, input, A_W: dividend, two's complement.
- b, input, B_W: divisor, two's complement.
- o_valid, output, 1: o, o_sat and o_dz are valid.
- o, output, O_W: signed quotient, Q(O_I_W).(O_F_W).
- o_sat, output, 1: result was clamped to SAT_HI or SAT_LO.
- o_dz, output, 1: divisor was zero.

## Operation
- **Stage 0 (input register):**
  - Register |a| as A_W-bit unsigned, so -2^(A_W-1) is representable; same for |b| in B_W bits.
  - Register sign = a[A_W-1] ^ b[B_W-1], plus dz = (b==0), az = (a==0) and valid.
- **Stages 1..NSTG (restoring division, R bits per stage, MSB first):**
  - The partial remainder is B_W+1 bits wide.
  - Each bit step: shift the remainder left, bringing in the next bit of the dividend {|a|, O_F_W zeros}. If remainder >= |b|, subtract |b| and emit quotient bit 1; otherwise emit 0.
  - Bits past Q_W in the last stage (when Q_W is not a multiple of R) are not computed; the quotient is exactly Q_W bits.
  - Divisor, sign, dz, az and valid travel alongside each stage.
- **Final stage (registered):**
  - Form signed q = sign ? -Q : Q at Q_W+1 bits.
  - dz & az: o = 0, o_dz = 1, o_sat = 0.
  - dz & !az: o = sign_a ? SAT_LO : SAT_HI, o_dz = 1, o_sat = 0. The sign of b is ignored here.
  - q > SAT_HI: o = SAT_HI, o_sat = 1.
  - q < SAT_LO: o = SAT_LO, o_sat = 1.
  - Otherwise o = q[O_W-1:0], o_sat = 0.
- **Valid and bubbles:**
  - A bubble (i_valid = 0 while i_en = 1) propagates with valid = 0.
  - Data registers behind an invalid slot may hold any value; o, o_sat and o_dz are only meaningful when o_valid = 1.
- **Reset:**
  - Clears every stage's valid bit, and clears o_valid, o, o_sat and o_dz to 0.
  - Reset asserted mid-stream discards all in-flight operations. The first result after reset is the pair presented on the first enabled cycle with i_valid = 1 after rst falls.
- **Reset vs. stall:** rst takes priority over i_en = 0.

## Timing
- Latency is LAT enabled cycles from the edge that samples i_valid to o_valid (default 14). Cycles with i_en = 0 do not count.
- Throughput is one operation per enabled cycle. There is no backpressure beyond i_en and no internal state machine; the block is a pure valid-qualified pipeline.
- With i_en = 0, o, o_valid, o_sat and o_dz hold their values. The same result may therefore be presented for multiple cycles; the consumer qualifies it with i_en.
- Critical path is R cascaded subtract/compare units of B_W+1 bits. R = 4 is for relaxed clocks only.

## Test plan
- **Basic quotients (defaults):**
  - a=3, b=1 -> o=20'h30000, o_sat=0, o_dz=0.
  - a=1, b=3 -> o=20'h05555.
  - a=-1, b=3 -> o=20'hFAAAB (truncation toward zero).
  - a=-128, b=-128 -> o=20'h10000.
  - Each result appears exactly 14 cycles after issue.
- **Saturation:**
  - a=10, b=1 -> o=20'h5ABD9, o_sat=1.
  - a=-10, b=1 -> o=20'hA5426, o_sat=1.
  - a=127, b=-1 -> o=20'hA5426, o_sat=1.
- **Divide by zero:**
  - a=5, b=0 -> o=20'h5ABD9, o_dz=1, o_sat=0.
  - a=-5, b=0 -> o=20'hA5426, o_dz=1.
  - a=0, b=0 -> o=0, o_dz=1.
- **Streaming:**
  - 1000 back-to-back random pairs with random bubbles, i_en=1.
  - Each o_valid beat matches a reference model, in order, with the bubble pattern preserved.
- **Stall:**
  - Random i_en deassertion during streaming: outputs hold while i_en=0.
  - No result is lost or duplicated when counted on enabled cycles; latency is 14 enabled cycles.
- **Reset:**
  - rst for 1 cycle with 10 operations in flight -> o_valid=0, o=0 the next cycle.
  - No stale result ever emerges; the first new pair issued after reset appears 14 cycles later.
  - Repeat with R=1 and R=4, A_W=B_W=12 (exhaustive corners).
